// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries the decoder control bundle through ID/EX, EX/MEM and MEM/WB, with hazard detection.
// CTRL_PIPE_FWD_EN defined: EX forwarding plus load-use stall. Undefined: full interlock, forwarding tied off.
module ctrl_pipe #(
  parameter int RW = 5,
  parameter int CW = 8
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic [CW-1:0] ctrl_i,
  input  logic [RW-1:0] rs_i,
  input  logic [RW-1:0] rt_i,
  input  logic [RW-1:0] rd_i,
  input  logic          flush_i,
  output logic          stall_o,
  output logic          ex_alusrc_o,
  output logic [1:0]    ex_aluop_o,
  output logic [RW-1:0] ex_rs_o,
  output logic [RW-1:0] ex_rt_o,
  output logic [1:0]    fwd_a_o,
  output logic [1:0]    fwd_b_o,
  output logic          mem_memread_o,
  output logic          mem_memwrite_o,
  output logic          wb_regwrite_o,
  output logic          wb_memtoreg_o,
  output logic [RW-1:0] wb_wreg_o
);

  localparam int B_REGWRITE = 7;
  localparam int B_MEMREAD  = 5;
  localparam int B_ALUSRC   = 3;
  localparam int B_REGDST   = 0;

  logic [CW-1:0] r_ctrl_p0;
  logic [RW-1:0] r_rs_p0;
  logic [RW-1:0] r_rt_p0;
  logic [RW-1:0] r_rd_p0;
  logic [3:0]    r_ctrl_p1;
  logic [RW-1:0] r_wreg_p1;
  logic          r_regwrite_p2;
  logic          r_memtoreg_p2;
  logic [RW-1:0] r_wreg_p2;

  logic [RW-1:0] w_wreg_ex;
  logic          w_loaduse;
  logic          w_bubble;

  assign w_wreg_ex = r_ctrl_p0[B_REGDST] ? r_rd_p0 : r_rt_p0;
  assign w_loaduse = r_ctrl_p0[B_MEMREAD] && (r_rt_p0 != '0) &&
                     ((r_rt_p0 == rs_i) || (r_rt_p0 == rt_i));
  assign w_bubble  = stall_o | flush_i;

`ifdef CTRL_PIPE_FWD_EN
  // Newest producer wins: EX/MEM is checked before MEM/WB.
  function automatic logic [1:0] fwd_sel(input logic [RW-1:0] src);
    if (r_ctrl_p1[3] && (r_wreg_p1 != '0) && (r_wreg_p1 == src))
      return 2'b10;
    else if (r_regwrite_p2 && (r_wreg_p2 != '0) && (r_wreg_p2 == src))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign stall_o = w_loaduse;
  assign fwd_a_o = fwd_sel(r_rs_p0);
  assign fwd_b_o = fwd_sel(r_rt_p0);
`else
  logic w_raw_ex;
  logic w_raw_mem;

  // WB-stage matches are covered by the write-before-read register file.
  assign w_raw_ex  = r_ctrl_p0[B_REGWRITE] && (w_wreg_ex != '0) &&
                     ((w_wreg_ex == rs_i) || (w_wreg_ex == rt_i));
  assign w_raw_mem = r_ctrl_p1[3] && (r_wreg_p1 != '0) &&
                     ((r_wreg_p1 == rs_i) || (r_wreg_p1 == rt_i));
  assign stall_o   = w_loaduse | w_raw_ex | w_raw_mem;
  assign fwd_a_o   = 2'b00;
  assign fwd_b_o   = 2'b00;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ctrl_p0     <= '0;
      r_rs_p0       <= '0;
      r_rt_p0       <= '0;
      r_rd_p0       <= '0;
      r_ctrl_p1     <= '0;
      r_wreg_p1     <= '0;
      r_regwrite_p2 <= 1'b0;
      r_memtoreg_p2 <= 1'b0;
      r_wreg_p2     <= '0;
    end else begin
      // ID/EX: a bubble zeroes the control so stray ctrl_i bits never propagate
      r_ctrl_p0     <= w_bubble ? '0 : ctrl_i;
      r_rs_p0       <= rs_i;
      r_rt_p0       <= rt_i;
      r_rd_p0       <= rd_i;
      // EX/MEM
      r_ctrl_p1     <= r_ctrl_p0[7:4];
      r_wreg_p1     <= w_wreg_ex;
      // MEM/WB
      r_regwrite_p2 <= r_ctrl_p1[3];
      r_memtoreg_p2 <= r_ctrl_p1[2];
      r_wreg_p2     <= r_wreg_p1;
    end
  end

  assign ex_alusrc_o    = r_ctrl_p0[B_ALUSRC];
  assign ex_aluop_o     = r_ctrl_p0[2:1];
  assign ex_rs_o        = r_rs_p0;
  assign ex_rt_o        = r_rt_p0;
  assign mem_memread_o  = r_ctrl_p1[1];
  assign mem_memwrite_o = r_ctrl_p1[0];
  assign wb_regwrite_o  = r_regwrite_p2;
  assign wb_memtoreg_o  = r_memtoreg_p2;
  assign wb_wreg_o      = r_wreg_p2;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed testbench for ctrl_pipe; expectations follow the build mode selected by CTRL_PIPE_FWD_EN.
module tb_ctrl_pipe;

  localparam logic [7:0] NOP  = 8'h00;
  localparam logic [7:0] RTYP = 8'h87;
  localparam logic [7:0] LW   = 8'hE8;
  localparam logic [7:0] SW   = 8'h18;
  localparam logic [7:0] ADDI = 8'h88;

  logic       clk_i = 1'b0;
  logic       rst_n_i = 1'b1;
  logic [7:0] ctrl_i = '0;
  logic [4:0] rs_i = '0, rt_i = '0, rd_i = '0;
  logic       flush_i = 1'b0;
  logic       stall_o, ex_alusrc_o, mem_memread_o, mem_memwrite_o;
  logic       wb_regwrite_o, wb_memtoreg_o;
  logic [1:0] ex_aluop_o, fwd_a_o, fwd_b_o;
  logic [4:0] ex_rs_o, ex_rt_o, wb_wreg_o;

  int n_chk  = 0;
  int n_pass = 0;

  ctrl_pipe #(.RW(5), .CW(8)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .ctrl_i(ctrl_i), .rs_i(rs_i), .rt_i(rt_i),
    .rd_i(rd_i), .flush_i(flush_i), .stall_o(stall_o), .ex_alusrc_o(ex_alusrc_o),
    .ex_aluop_o(ex_aluop_o), .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o), .fwd_a_o(fwd_a_o),
    .fwd_b_o(fwd_b_o), .mem_memread_o(mem_memread_o), .mem_memwrite_o(mem_memwrite_o),
    .wb_regwrite_o(wb_regwrite_o), .wb_memtoreg_o(wb_memtoreg_o), .wb_wreg_o(wb_wreg_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic issue(input logic [7:0] c, input logic [4:0] s, input logic [4:0] t,
                       input logic [4:0] d, input logic f);
    ctrl_i = c; rs_i = s; rt_i = t; rd_i = d; flush_i = f;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain();
    repeat (3) begin
      issue(NOP, 0, 0, 0, 0);
      tick();
    end
  endtask

  initial begin
    // Reset asserted with no clock edge
    #2 rst_n_i = 1'b0;
    #1;
    chk("rst_stall", stall_o, 0);
    chk("rst_ex", {ex_alusrc_o, ex_aluop_o, ex_rs_o, ex_rt_o}, 0);
    chk("rst_fwd", {fwd_a_o, fwd_b_o}, 0);
    chk("rst_mem", {mem_memread_o, mem_memwrite_o}, 0);
    chk("rst_wb", {wb_regwrite_o, wb_memtoreg_o, wb_wreg_o}, 0);
    tick(); tick();
    rst_n_i = 1'b1;

    // Latency of an r-type through the three registers
    issue(RTYP, 1, 2, 3, 0);
    chk("lat_stall", stall_o, 0);
    tick();
    chk("lat_ex_aluop", ex_aluop_o, 2'b11);
    chk("lat_ex_rs", ex_rs_o, 1);
    chk("lat_wb_early", wb_regwrite_o, 0);
    issue(NOP, 0, 0, 0, 0); tick();
    chk("lat_mem", {mem_memread_o, mem_memwrite_o}, 0);
    tick();
    chk("lat_wb_rw", wb_regwrite_o, 1);
    chk("lat_wb_wreg", wb_wreg_o, 3);
    chk("lat_wb_m2r", wb_memtoreg_o, 0);

    // Reset mid-cycle with a lw in EX and an addi in MEM
    drain();
    issue(ADDI, 0, 7, 0, 0); tick();
    issue(LW, 0, 5, 0, 0);
    chk("mr_pre_stall", stall_o, 0);
    tick();
    chk("mr_ex_alusrc", ex_alusrc_o, 1);
    chk("mr_ex_rt", ex_rt_o, 5);
    issue(NOP, 5, 0, 0, 0);
    chk("mr_lu_stall", stall_o, 1);
    rst_n_i = 1'b0;
    #1;
    chk("mr_stall", stall_o, 0);
    chk("mr_ex", {ex_alusrc_o, ex_aluop_o, ex_rt_o}, 0);
    chk("mr_mem", {mem_memread_o, mem_memwrite_o}, 0);
    tick();
    rst_n_i = 1'b1;
    issue(RTYP, 1, 2, 6, 0); tick();
    chk("mr_first_ex", {ex_aluop_o, ex_rs_o}, {2'b11, 5'd1});
    issue(NOP, 0, 0, 0, 0); tick(); tick();
    chk("mr_no_wb", {wb_regwrite_o, wb_wreg_o}, {1'b1, 5'd6});

    // Load-use: lw r5 then add rs=5
    drain();
    issue(LW, 0, 5, 0, 0); tick();
    issue(RTYP, 5, 6, 8, 0);
    chk("lu_stall", stall_o, 1);
    tick();
    chk("lu_bubble", ex_aluop_o, 0);
    chk("lu_mem_rd", mem_memread_o, 1);
`ifdef CTRL_PIPE_FWD_EN
    issue(RTYP, 5, 6, 8, 0);
    chk("lu_stall_end", stall_o, 0);
    tick();
    chk("lu_ex_aluop", ex_aluop_o, 2'b11);
    chk("lu_fwd_a", fwd_a_o, 2'b01);
    chk("lu_fwd_b", fwd_b_o, 2'b00);
    chk("lu_wb", {wb_memtoreg_o, wb_wreg_o}, {1'b1, 5'd5});
`else
    issue(RTYP, 5, 6, 8, 0);
    chk("il_lu_stall2", stall_o, 1);
    tick();
    chk("il_lu_bubble2", ex_aluop_o, 0);
    chk("il_lu_wb", {wb_memtoreg_o, wb_wreg_o}, {1'b1, 5'd5});
    issue(RTYP, 5, 6, 8, 0);
    chk("il_lu_stall_end", stall_o, 0);
    tick();
    chk("il_lu_ex_aluop", ex_aluop_o, 2'b11);
    chk("il_lu_fwd", {fwd_a_o, fwd_b_o}, 0);
`endif

    // Back-to-back producers of r4, then a consumer
    drain();
    issue(RTYP, 1, 2, 4, 0); tick();
    issue(RTYP, 1, 2, 4, 0);
    chk("pr_stall0", stall_o, 0);
    tick();
    issue(RTYP, 4, 9, 10, 0);
`ifdef CTRL_PIPE_FWD_EN
    chk("pr_stall1", stall_o, 0);
    tick();
    chk("pr_fwd_a", fwd_a_o, 2'b10);
    chk("pr_fwd_b", fwd_b_o, 2'b00);
    issue(RTYP, 0, 4, 11, 0);
    chk("pr_stall2", stall_o, 0);
    tick();
    chk("pr_fwd_b_wb", fwd_b_o, 2'b01);
    chk("pr_fwd_a_r0", fwd_a_o, 2'b00);
`else
    chk("il_stall_c1", stall_o, 1);
    tick();
    chk("il_bubble_c1", ex_aluop_o, 0);
    chk("il_fwd_c1", {fwd_a_o, fwd_b_o}, 0);
    issue(RTYP, 4, 9, 10, 0);
    chk("il_stall_c2", stall_o, 1);
    tick();
    issue(RTYP, 4, 9, 10, 0);
    chk("il_stall_c3", stall_o, 0);
    tick();
    chk("il_sub_ex", {ex_aluop_o, ex_rs_o}, {2'b11, 5'd4});
    chk("il_fwd_end", {fwd_a_o, fwd_b_o}, 0);
`endif

    // Register zero never forwards or stalls, then a flushed sw
    drain();
    issue(ADDI, 1, 0, 0, 0); tick();
    issue(RTYP, 0, 0, 3, 0);
    chk("r0_stall", stall_o, 0);
    tick();
    chk("r0_fwd", {fwd_a_o, fwd_b_o}, 0);
    issue(SW, 1, 2, 0, 1);
    chk("fl_stall", stall_o, 0);
    tick();
    chk("fl_ex_alusrc", ex_alusrc_o, 0);
    issue(NOP, 0, 0, 0, 0); tick();
    chk("fl_mem_wr", mem_memwrite_o, 0);

    // Flush together with a load-use stall, then X on ctrl_i under flush
    drain();
    issue(LW, 0, 5, 0, 0); tick();
    issue(RTYP, 5, 6, 7, 1);
    chk("fs_stall", stall_o, 1);
    tick();
    chk("fs_bubble", {ex_alusrc_o, ex_aluop_o}, 0);
    issue(8'bxxxx_xxxx, 0, 0, 0, 1);
    chk("fx_stall", stall_o, 0);
    tick();
    chk("fx_ex", {ex_alusrc_o, ex_aluop_o}, 0);
    chk("fx_mem", {mem_memread_o, mem_memwrite_o}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Consumes the 8-bit control bundle produced by the opcode decoder in ID and carries it through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Bundle layout: [7] RegWrite, [6] MemtoReg, [5] MemRead, [4] MemWrite, [3] ALUSrc, [2:1] ALUOp, [0] RegDst.
- Exposes per-stage control fields and destination-register tracking.
- Detects load-use hazards (stall plus bubble insertion) and produces EX-stage forwarding selects.
- Sits between the decoder and the datapath.

Parameters:
- RW, 5, register-index width.
- CW, 8, control-bundle width; fixed layout above, not overridable in function.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- ctrl_i  in  8  control bundle from the decoder for the instruction in ID.
- rs_i  in  RW  ID-stage rs field.
- rt_i  in  RW  ID-stage rt field.
- rd_i  in  RW  ID-stage rd field.
- flush_i  in  1  squash the ID instruction (taken branch or jump).
- stall_o  out  1  hold PC and IF/ID; combinational.
- ex_alusrc_o  out  1  ALUSrc in EX.
- ex_aluop_o  out  2  ALUOp in EX.
- ex_rs_o  out  RW  registered rs in EX.
- ex_rt_o  out  RW  registered rt in EX.
- fwd_a_o  out  2  ALU operand-A select: 00 regfile, 10 EX/MEM result, 01 MEM/WB result.
- fwd_b_o  out  2  ALU operand-B select; same encoding.
- mem_memread_o  out  1  MemRead in MEM.
- mem_memwrite_o  out  1  MemWrite in MEM.
- wb_regwrite_o  out  1  RegWrite in WB.
- wb_memtoreg_o  out  1  MemtoReg in WB.
- wb_wreg_o  out  RW  write-back destination register.

Behaviour:
- Reset (rst_n_i low, asynchronous): every pipeline register clears to 0. All registered outputs read 0 until the first edge after release. No reset synchronizer inside.
- ID/EX register: on each edge loads ctrl_i, rs_i, rt_i, rd_i.
- Bubble insertion: if stall_o or flush_i is high at the edge, the ID/EX control field loads 8'h00. Register fields still load but are don't-care because RegWrite, MemRead and MemWrite are 0.
- EX destination: ex_wreg = RegDst ? rd : rt, computed combinationally from the ID/EX fields. It is registered into EX/MEM with bits [7:4] of control.
- MEM/WB register: loads RegWrite, MemtoReg and wreg from EX/MEM.
- EX/MEM and MEM/WB always advance; they never stall.
- Latency: ctrl_i sampled at edge k appears on ex_* after edge k, on mem_* after edge k+1, and on wb_* after edge k+2.
- Load-use stall: stall_o = ID/EX MemRead AND ex_rt != 0 AND (ex_rt == rs_i OR ex_rt == rt_i).
  - Stall lasts exactly one cycle, because the bubble clears the EX MemRead next cycle.
- Forwarding A: 10 if EX/MEM RegWrite AND mem_wreg != 0 AND mem_wreg == ex_rs; else 01 if MEM/WB RegWrite AND wb_wreg != 0 AND wb_wreg == ex_rs; else 00.
  - EX/MEM has priority over MEM/WB (newest value wins).
  - Forwarding B is identical using ex_rt.
- Register 0 is never a hazard source or forward target.
- Simultaneous flush_i and stall_o: single bubble. stall_o is still asserted, and upstream gives flush priority for PC update.
- Reset mid-stream: all in-flight control is discarded immediately and no write-back occurs. The first instruction after release enters cleanly.
- No X propagation: ctrl_i values with X on unused bits must not reach outputs when flush_i or stall_o is high.

Optional Feature:
- Macro: CTRL_PIPE_FWD_EN.
- Defined: forwarding logic as above; stall_o covers load-use only.
- Undefined:
  - fwd_a_o and fwd_b_o are tied to 00.
  - stall_o additionally asserts when rs_i or rt_i (nonzero) matches ex_wreg with ID/EX RegWrite, or mem_wreg with EX/MEM RegWrite.
  - This is a full interlock. The register file is assumed write-before-read, so a WB-stage match does not stall.
  - Bubbles are inserted identically.

Test Plan:
- Reset: assert rst_n_i low mid-cycle with a lw in EX. All outputs go 0 immediately, with no clock edge needed, and stall_o = 0.
- Latency: issue r-type ctrl_i=8'h87 (rd=3). Next cycle ex_aluop_o=2'b11. Two cycles later mem_* = 0. Three cycles later wb_regwrite_o=1 and wb_wreg_o=3.
- Load-use: lw ctrl 8'hE8 (rt=5), followed by add with rs=5. stall_o=1 for exactly one cycle and a bubble enters EX. The add then proceeds with fwd_a_o=01 (from MEM/WB).
- Forward priority: add r4 followed immediately by add r4, then sub rs=4. Expect fwd_a_o=10 (EX/MEM wins over MEM/WB).
- Register zero / flush: addi writing rt=0, followed by a use of r0. Expect fwd=00 and no stall. Then flush_i=1 with a sw in ID. mem_memwrite_o stays 0 two cycles later.
- Without CTRL_PIPE_FWD_EN: add r2 followed by sub rs=2 gives stall_o=1 for 2 cycles, and fwd outputs stay 00 throughout.
